// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared constants, lane state type and symbol classifier for serdes_link_sync
//
// Purpose: common definitions for the lane synchronisers and the link top.
//   K28_5         idle / comma byte
//   lane_state_t  per-lane acquisition state
//   sym_class_t   error / good / comma flags for one received symbol
//   classify()    derives sym_class_t from the decoder outputs of one lane
package serdes_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;

    typedef enum logic [1:0] {
        LOS  = 2'd0,
        ACQ  = 2'd1,
        SYNC = 2'd2
    } lane_state_t;

    typedef struct packed {
        logic err;
        logic good;
        logic comma;
    } sym_class_t;

    // Error and good are both qualified by valid, so an idle cycle is neither.
    function automatic sym_class_t classify(
        input logic       valid,
        input logic [7:0] data,
        input logic       k,
        input logic       code_err,
        input logic       disp_err
    );
        sym_class_t c;
        c.err   = valid & (code_err | disp_err);
        c.good  = valid & ~(code_err | disp_err);
        c.comma = c.good & k & (data == K28_5);
        return c;
    endfunction

endpackage

// File: rtl/serdes_lane_sync.sv
// rtl/serdes_lane_sync.sv - per-lane comma acquisition, windowed loss-of-sync and error counter
//
// Purpose: tracks one lane through LOS -> ACQ -> SYNC and counts its symbol errors.
// Ports:
//   clk_byte        in   byte clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   i_rx_data[7:0]  in   decoded byte
//   i_rx_k          in   control-symbol flag
//   i_rx_valid      in   symbol valid; nothing changes when low
//   i_rx_code_err   in   code violation
//   i_rx_disp_err   in   disparity error
//   i_err_clr       in   clear pulse for the error counter
//   o_lane_sync     out  registered (state == SYNC)
//   o_err_cnt[15:0] out  saturating error count
module serdes_lane_sync
    import serdes_pkg::*;
#(
    parameter int GOOD_THRESH = 16,
    parameter int ERR_BUDGET  = 4,
    parameter int ERR_WINDOW  = 256
) (
    input  logic        clk_byte,
    input  logic        rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_k,
    input  logic        i_rx_valid,
    input  logic        i_rx_code_err,
    input  logic        i_rx_disp_err,
    input  logic        i_err_clr,
    output logic        o_lane_sync,
    output logic [15:0] o_err_cnt
);

    // Terminal values: the symbol seen while the counter holds these closes the phase.
    localparam logic [7:0]  GOOD_LAST = 8'(GOOD_THRESH - 1);
    localparam logic [7:0]  ERR_LAST  = 8'(ERR_BUDGET - 1);
    localparam logic [15:0] WIN_LAST  = 16'(ERR_WINDOW - 1);

    lane_state_t r_state;
    logic [7:0]  r_good_cnt;
    logic [15:0] r_win_cnt;
    logic [7:0]  r_win_err;
    logic        r_lane_sync;
    logic [15:0] r_err_cnt;
    sym_class_t  w_cls;

    assign w_cls = classify(i_rx_valid, i_rx_data, i_rx_k, i_rx_code_err, i_rx_disp_err);

    always_ff @(posedge clk_byte or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= LOS;
            r_good_cnt  <= 8'd0;
            r_win_cnt   <= 16'd0;
            r_win_err   <= 8'd0;
            r_lane_sync <= 1'b0;
            r_err_cnt   <= 16'd0;
        end else begin
            r_lane_sync <= (r_state == SYNC);

            // A clear coincident with an error keeps that error: counter restarts at 1.
            if (i_err_clr) begin
                r_err_cnt <= {15'd0, w_cls.err};
            end else if (w_cls.err && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end

            case (r_state)
                LOS: begin
                    if (w_cls.comma) begin
                        r_state    <= ACQ;
                        r_good_cnt <= 8'd0;
                    end
                end
                ACQ: begin
                    if (w_cls.err) begin
                        r_state <= LOS;
                    end else if (w_cls.good) begin
                        if (r_good_cnt == GOOD_LAST) begin
                            r_state   <= SYNC;
                            r_win_cnt <= 16'd0;
                            r_win_err <= 8'd0;
                        end else begin
                            r_good_cnt <= r_good_cnt + 8'd1;
                        end
                    end
                end
                SYNC: begin
                    if (i_rx_valid) begin
                        // Budget exhaustion wins over window close on the same symbol.
                        if (w_cls.err && (r_win_err == ERR_LAST)) begin
                            r_state <= LOS;
                        end else if (r_win_cnt == WIN_LAST) begin
                            r_win_cnt <= 16'd0;
                            r_win_err <= 8'd0;
                        end else begin
                            r_win_cnt <= r_win_cnt + 16'd1;
                            if (w_cls.err) begin
                                r_win_err <= r_win_err + 8'd1;
                            end
                        end
                    end
                end
                default: r_state <= LOS;
            endcase
        end
    end

    assign o_lane_sync = r_lane_sync;
    assign o_err_cnt   = r_err_cnt;

endmodule

// File: rtl/serdes_link_sync.sv
// rtl/serdes_link_sync.sv - multi-lane link synchroniser with K28.5 idle insertion on transmit
//
// Purpose: one serdes_lane_sync per lane, link_ready aggregation and the TX idle mux.
// Ports:
//   clk_byte, rst_n                  byte clock, asynchronous active-low reset
//   i_rx_data[8*LANES]               decoded bytes, lane i at [8i+7:8i]
//   i_rx_k/valid/code_err/disp_err   per-lane decoder flags
//   i_err_clr                        clears every lane error counter
//   o_lane_sync[LANES]               per-lane SYNC indication
//   o_link_ready                     all lanes in sync (registered)
//   o_lane_err_cnt[16*LANES]         saturating error counts
//   i_tx_data/i_tx_k/i_tx_valid      user transmit symbols, all lanes together
//   o_tx_ready                       equals o_link_ready
//   o_enc_data/o_enc_k               registered symbols to the encoders
module serdes_link_sync
    import serdes_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int GOOD_THRESH = 16,
    parameter int ERR_BUDGET  = 4,
    parameter int ERR_WINDOW  = 256
) (
    input  logic                 clk_byte,
    input  logic                 rst_n,
    input  logic [8*LANES-1:0]   i_rx_data,
    input  logic [LANES-1:0]     i_rx_k,
    input  logic [LANES-1:0]     i_rx_valid,
    input  logic [LANES-1:0]     i_rx_code_err,
    input  logic [LANES-1:0]     i_rx_disp_err,
    input  logic                 i_err_clr,
    output logic [LANES-1:0]     o_lane_sync,
    output logic                 o_link_ready,
    output logic [16*LANES-1:0]  o_lane_err_cnt,
    input  logic [8*LANES-1:0]   i_tx_data,
    input  logic [LANES-1:0]     i_tx_k,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic [8*LANES-1:0]   o_enc_data,
    output logic [LANES-1:0]     o_enc_k
);

    logic [LANES-1:0]    w_lane_sync;
    logic [16*LANES-1:0] w_err_cnt;
    logic                r_link_ready;
    logic [8*LANES-1:0]  r_enc_data;
    logic [LANES-1:0]    r_enc_k;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        serdes_lane_sync #(
            .GOOD_THRESH (GOOD_THRESH),
            .ERR_BUDGET  (ERR_BUDGET),
            .ERR_WINDOW  (ERR_WINDOW)
        ) u_lane (
            .clk_byte      (clk_byte),
            .rst_n         (rst_n),
            .i_rx_data     (i_rx_data[8*g +: 8]),
            .i_rx_k        (i_rx_k[g]),
            .i_rx_valid    (i_rx_valid[g]),
            .i_rx_code_err (i_rx_code_err[g]),
            .i_rx_disp_err (i_rx_disp_err[g]),
            .i_err_clr     (i_err_clr),
            .o_lane_sync   (w_lane_sync[g]),
            .o_err_cnt     (w_err_cnt[16*g +: 16])
        );
    end

    // User symbols offered while not ready are dropped; the link idles on K28.5.
    always_ff @(posedge clk_byte or negedge rst_n) begin
        if (!rst_n) begin
            r_link_ready <= 1'b0;
            r_enc_data   <= {LANES{K28_5}};
            r_enc_k      <= {LANES{1'b1}};
        end else begin
            r_link_ready <= &w_lane_sync;
            if (r_link_ready && i_tx_valid) begin
                r_enc_data <= i_tx_data;
                r_enc_k    <= i_tx_k;
            end else begin
                r_enc_data <= {LANES{K28_5}};
                r_enc_k    <= {LANES{1'b1}};
            end
        end
    end

    assign o_lane_sync    = w_lane_sync;
    assign o_lane_err_cnt = w_err_cnt;
    assign o_link_ready   = r_link_ready;
    assign o_tx_ready     = r_link_ready;
    assign o_enc_data     = r_enc_data;
    assign o_enc_k        = r_enc_k;

endmodule

// File: tb/tb_serdes_link_sync.sv
// tb/tb_serdes_link_sync.sv - directed self-checking bench for serdes_link_sync
module tb_serdes_link_sync;

    localparam int LANES = 4;

    logic                 clk_byte = 1'b0;
    logic                 rst_n;
    logic [8*LANES-1:0]   rx_data;
    logic [LANES-1:0]     rx_k, rx_valid, rx_code_err, rx_disp_err;
    logic                 err_clr;
    logic [LANES-1:0]     lane_sync;
    logic                 link_ready;
    logic [16*LANES-1:0]  lane_err_cnt;
    logic [8*LANES-1:0]   tx_data;
    logic [LANES-1:0]     tx_k;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [8*LANES-1:0]   enc_data;
    logic [LANES-1:0]     enc_k;

    typedef struct packed {
        logic [8*LANES-1:0] d;
        logic [LANES-1:0]   k;
    } enc_t;

    enc_t exp_q[$];
    int   n_vec = 0;
    int   n_mis = 0;
    logic exp_ready = 1'b0;

    always #5 clk_byte = ~clk_byte;

    serdes_link_sync #(
        .LANES       (LANES),
        .GOOD_THRESH (16),
        .ERR_BUDGET  (4),
        .ERR_WINDOW  (256)
    ) dut (
        .clk_byte       (clk_byte),
        .rst_n          (rst_n),
        .i_rx_data      (rx_data),
        .i_rx_k         (rx_k),
        .i_rx_valid     (rx_valid),
        .i_rx_code_err  (rx_code_err),
        .i_rx_disp_err  (rx_disp_err),
        .i_err_clr      (err_clr),
        .o_lane_sync    (lane_sync),
        .o_link_ready   (link_ready),
        .o_lane_err_cnt (lane_err_cnt),
        .i_tx_data      (tx_data),
        .i_tx_k         (tx_k),
        .i_tx_valid     (tx_valid),
        .o_tx_ready     (tx_ready),
        .o_enc_data     (enc_data),
        .o_enc_k        (enc_k)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int l, input logic [7:0] d, input logic k,
                            input logic v, input logic ce, input logic de);
        rx_data[8*l +: 8] = d;
        rx_k[l]           = k;
        rx_valid[l]       = v;
        rx_code_err[l]    = ce;
        rx_disp_err[l]    = de;
    endtask

    // Good non-comma data on every lane (k=0 so never a comma) plus fresh TX data.
    task automatic good_all();
        for (int l = 0; l < LANES; l++) begin
            set_lane(l, 8'($urandom_range(0, 127)), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        tx_data = $urandom;
        tx_k    = 4'($urandom_range(0, 15));
    endtask

    task automatic comma_lane(input int l);
        set_lane(l, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // Expected encoder output is queued from the inputs and the model's view of
    // tx_ready before the edge, then popped and compared after the edge.
    task automatic tick();
        enc_t e;
        if (tx_valid && exp_ready) begin
            e.d = tx_data;
            e.k = tx_k;
        end else begin
            e.d = {LANES{8'hBC}};
            e.k = {LANES{1'b1}};
        end
        exp_q.push_back(e);
        @(posedge clk_byte);
        #1;
        e = exp_q.pop_front();
        chk("enc_data", enc_data, e.d);
        chk("enc_k", enc_k, e.k);
    endtask

    initial begin
        rst_n       = 1'b0;
        rx_data     = '0;
        rx_k        = '0;
        rx_valid    = '0;
        rx_code_err = '0;
        rx_disp_err = '0;
        err_clr     = 1'b0;
        tx_data     = '0;
        tx_k        = '0;
        tx_valid    = 1'b0;
        tick();
        tick();
        chk("rst_lane_sync", lane_sync, 4'h0);
        chk("rst_link_ready", link_ready, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b0);
        chk("rst_err_cnt", lane_err_cnt, 64'h0);
        rst_n = 1'b1;

        // Acquisition on all lanes; TX offered throughout and dropped until ready.
        tx_valid = 1'b1;
        for (int l = 0; l < LANES; l++) comma_lane(l);
        tick();
        for (int j = 1; j <= 20; j++) begin
            good_all();
            tick();
            chk("acq_lane_sync", lane_sync, (j >= 17) ? 4'hF : 4'h0);
            chk("acq_link_ready", link_ready, (j >= 18));
            chk("acq_tx_ready", tx_ready, (j >= 18));
            exp_ready = (j >= 18);
        end

        // Lane 2 in SYNC: three errors tolerated, fourth in the same window drops it.
        for (int t = 1; t <= 22; t++) begin
            good_all();
            if (t == 1)  set_lane(2, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
            if (t == 7)  set_lane(2, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1);
            if (t == 13) set_lane(2, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1);
            if (t == 19) set_lane(2, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
            chk("budget_lane_sync", lane_sync, (t >= 20) ? 4'hB : 4'hF);
            chk("budget_link_ready", link_ready, (t < 21));
            exp_ready = (t < 21);
        end
        chk("budget_err_cnt", lane_err_cnt, 64'h0000_0004_0000_0000);
        good_all();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_err_cnt", lane_err_cnt, 64'h0);

        // Lane 2 in ACQ: error on the 10th symbol after the comma returns it to LOS.
        good_all();
        comma_lane(2);
        tick();
        for (int t = 1; t <= 30; t++) begin
            good_all();
            if (t == 10) set_lane(2, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
            chk("acqerr_lane_sync", lane_sync, 4'hB);
        end
        chk("acqerr_err_cnt", lane_err_cnt, 64'h0000_0001_0000_0000);
        good_all();
        comma_lane(2);
        tick();
        for (int t = 1; t <= 16; t++) begin
            good_all();
            tick();
            chk("resync_lane_sync", lane_sync, 4'hB);
        end

        // Window: 3 errors, window closes on symbol 256, 3 more, 4th on symbol 512 (closing).
        for (int s = 1; s <= 514; s++) begin
            good_all();
            if (s == 10 || s == 20 || s == 30 || s == 260 || s == 270 || s == 280 || s == 512)
                set_lane(2, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
            if (s == 1 || s == 2 || s == 255 || s == 256 || s == 300 ||
                s == 511 || s == 512 || s == 513 || s == 514) begin
                chk("win_lane_sync", lane_sync, (s >= 513) ? 4'hB : 4'hF);
                chk("win_link_ready", link_ready, (s >= 2 && s < 514));
            end
            exp_ready = (s >= 2 && s < 514);
        end
        chk("win_err_cnt", lane_err_cnt, 64'h0000_0008_0000_0000);

        // Saturation on lane 3, then clear coincident with an error.
        tx_valid  = 1'b0;
        exp_ready = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            good_all();
            set_lane(3, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        chk("sat_err_cnt3", lane_err_cnt[63:48], 16'hFFFF);
        chk("sat_err_cnt2", lane_err_cnt[47:32], 16'h0008);
        chk("sat_lane_sync", lane_sync, 4'h3);
        good_all();
        set_lane(3, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_err_err_cnt", lane_err_cnt, 64'h0001_0000_0000_0000);
        good_all();
        tick();
        chk("post_clr_err_cnt", lane_err_cnt, 64'h0001_0000_0000_0000);

        // Asynchronous reset with lanes 0/1 in SYNC: outputs drop without a clock edge.
        rst_n = 1'b0;
        #1;
        chk("arst_lane_sync", lane_sync, 4'h0);
        chk("arst_link_ready", link_ready, 1'b0);
        chk("arst_tx_ready", tx_ready, 1'b0);
        chk("arst_err_cnt", lane_err_cnt, 64'h0);
        chk("arst_enc_data", enc_data, 32'hBCBC_BCBC);
        chk("arst_enc_k", enc_k, 4'hF);
        tick();
        tick();
        rst_n = 1'b1;

        // Only a comma starts acquisition; 50 invalid cycles freeze good_cnt.
        for (int t = 0; t < 3; t++) begin
            good_all();
            tick();
        end
        for (int l = 0; l < LANES; l++) comma_lane(l);
        tick();
        for (int t = 1; t <= 70; t++) begin
            good_all();
            if (t > 5 && t <= 55) begin
                for (int l = 0; l < LANES; l++) set_lane(l, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);
            end
            tick();
            chk("gate_lane_sync", lane_sync, (t >= 67) ? 4'hF : 4'h0);
        end
        chk("gate_err_cnt", lane_err_cnt, 64'h0);
        chk("gate_link_ready", link_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/serdes_link_sync.md
# serdes_link_sync

Parametrised multi-lane link synchroniser and idle inserter for the 8b/10b SERDES datapath. It sits between the per-lane 8b/10b decoders/encoders and the user logic, all in the byte-clock domain. It replaces the single-lane "count N good symbols" link-ready logic with three additions:
- a per-lane comma-qualified acquisition FSM,
- windowed error-budget loss-of-sync,
- saturating error counters and K28.5 idle insertion on transmit.

## Interface
- LANES, 4, number of lanes (1..16)
- GOOD_THRESH, 16, consecutive good symbols after comma required for sync (2..255)
- ERR_BUDGET, 4, errors within one window that drop sync (1..255)
- ERR_WINDOW, 256, valid-symbol window length for error budget (2..65535)
- clk_byte  in  1  byte clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  8*LANES  decoded bytes, lane i at [8i+7:8i]
- rx_k  in  LANES  control-symbol flag per lane
- rx_valid  in  LANES  decoded symbol valid per lane
- rx_code_err  in  LANES  code-violation flag (qualified by rx_valid)
- rx_disp_err  in  LANES  disparity-error flag (qualified by rx_valid)
- err_clr  in  1  single-cycle pulse, clears all error counters
- lane_sync  out  LANES  lane i in SYNC state
- link_ready  out  1  all lanes in SYNC
- lane_err_cnt  out  16*LANES  saturating error count per lane
- tx_data  in  8*LANES  user transmit bytes
- tx_k  in  LANES  user control flags
- tx_valid  in  1  user symbol valid (all lanes together)
- tx_ready  out  1  equals link_ready
- enc_data  out  8*LANES  bytes to encoders
- enc_k  out  LANES  control flags to encoders

## Operation
- A symbol is counted only when rx_valid[i]=1. Cycles with rx_valid[i]=0 change no lane-i state or counter.
- Error: rx_valid & (rx_code_err | rx_disp_err). Good: valid and not error. Comma: good & rx_k & data==8'hBC.
- Per-lane FSM states:
  - LOS (reset state): comma -> ACQ, good_cnt=0.
  - ACQ: error -> LOS. Each good symbol increments good_cnt; the good symbol that brings good_cnt to GOOD_THRESH -> SYNC. Commas count as good.
  - SYNC: on SYNC entry, win_cnt=0 and win_err=0. Each valid symbol increments win_cnt; each error increments win_err. If win_err+1 reaches ERR_BUDGET on an error -> LOS. This check happens before the window end in the same cycle. When win_cnt reaches ERR_WINDOW-1 on a valid symbol without a LOS transition, win_cnt and win_err both clear to 0.
- lane_err_cnt[i] increments on every error in any state and saturates at 16'hFFFF.
  - err_clr alone sets the counter to 0.
  - err_clr together with an error sets it to 1.
- lane_sync[i] = (state==SYNC), registered. link_ready = &lane_sync, registered.
- TX path:
  - If tx_ready & tx_valid: enc_data/enc_k = tx_data/tx_k.
  - Otherwise, every lane gets K28.5 (enc_data=8'hBC, enc_k=1).
  - User symbols offered while tx_ready=0 are discarded, not queued.

## Timing
- Reset values: lane_sync=0, link_ready=0, lane_err_cnt=0, enc_data=8'hBC on every lane, enc_k=all 1, tx_ready=0. All FSMs are in LOS.
- A symbol at edge n that causes a transition updates lane_sync at edge n+1 and link_ready at edge n+2.
- Minimum time to sync from LOS: 1 comma + GOOD_THRESH good symbols. With GOOD_THRESH=16 and continuous valid, lane_sync rises 17 cycles after the comma.
- TX latency is 1 cycle; tx_ready is sampled in the same cycle as tx_valid.
- An asserted rst_n mid-operation returns all state to reset values immediately (asynchronous). The first comma after release restarts acquisition.
- Any single lane dropping to LOS deasserts link_ready one cycle after that lane's lane_sync falls.

## Structure
- Shared package serdes_pkg holds:
  - K28_5 = 8'hBC,
  - lane_state_t enum {LOS, ACQ, SYNC},
  - the error and comma classification function.
- Sub-module serdes_lane_sync: one instance per lane via generate. It contains the FSM, good_cnt, win_cnt, win_err and lane_err_cnt.
- Top level contains the link_ready register and the TX idle mux.

## Test plan
- Reset, LANES=4, continuous valid commas then data on all lanes -> lane_sync=4'hF 17 cycles after the first comma, link_ready one cycle later; enc_data=8'hBC/enc_k=1 until link_ready, after which tx_data passes through with 1-cycle latency.
- Lane 2 in ACQ, code error on 10th good symbol -> lane 2 to LOS; re-sync only after a new comma plus 16 good symbols; lane_err_cnt[2]=1.
- SYNC, ERR_BUDGET=4, 3 errors within 256 symbols -> stays SYNC; 4th error inside the same window -> LOS, link_ready falls 2 cycles after the symbol.
- SYNC, 3 errors, then window expires (256th valid symbol), then 3 more errors -> lane remains SYNC; an error on the window-closing symbol as the 4th error -> LOS.
- Force 70000 errors -> lane_err_cnt holds 16'hFFFF; err_clr coincident with an error -> counter reads 1.
- rx_valid gated low for 50 cycles mid-ACQ -> good_cnt frozen, sync time extended by exactly 50 cycles; rst_n asserted mid-SYNC -> all outputs at reset values immediately.
